// File: rtl/multiplexor_display_if.sv
// multiplexor_display_if: decoder-side inputs and display-pin outputs of the scan driver.
interface multiplexor_display_if;
    logic       en;
    logic [7:0] catodo1;
    logic [7:0] catodo2;
    logic [7:0] catodo3;
    logic [7:0] catodo4;
    logic [3:0] anodo;
    logic [7:0] catodo;
    logic [1:0] digito;
    logic       frame_tick;
    modport master (output en, catodo1, catodo2, catodo3, catodo4, input anodo, catodo, digito, frame_tick);
    modport slave (input en, catodo1, catodo2, catodo3, catodo4, output anodo, catodo, digito, frame_tick);
endinterface

// File: rtl/multiplexor_display.sv
// multiplexor_display: scans four active-low segment patterns onto a shared cathode bus,
// one anode at a time, blanking the first BLANK_CYC cycles of every slot.
module multiplexor_display #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 500,
    parameter int CW        = 16
) (
    input logic                  clk,
    input logic                  reset,
    multiplexor_display_if.slave io
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d, digito_q, digito_d;
    logic [7:0]    seg_q, seg_d, catodo_q, catodo_d, sel;
    logic [3:0]    anodo_q, anodo_d;
    logic          tick_q, tick_d, wrap, blank;

    // Outputs are computed from the current count so they land one cycle after it.
    always_comb begin
        sel      = idx_q == 2'd0 ? io.catodo1 : idx_q == 2'd1 ? io.catodo2 :
                   idx_q == 2'd2 ? io.catodo3 : io.catodo4;
        wrap     = cnt_q == CW'(DIV - 1);
        blank    = (BLANK_CYC != 0) && (cnt_q < CW'(BLANK_CYC));
        cnt_d    = io.en ? (wrap ? '0 : cnt_q + 1'b1) : '0;
        idx_d    = io.en ? idx_q + 2'(wrap) : 2'd0;
        seg_d    = (io.en && cnt_q == CW'(BLANK_CYC)) ? sel : seg_q;
        anodo_d  = (io.en && !blank) ? ~(4'b0001 << idx_q) : 4'hF;
        catodo_d = (io.en && !blank) ? seg_d : 8'hFF;
        digito_d = io.en ? idx_q : 2'd0;
        tick_d   = io.en && wrap && idx_q == 2'd3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            seg_q    <= 8'hFF;
            anodo_q  <= 4'hF;
            catodo_q <= 8'hFF;
            digito_q <= 2'd0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            anodo_q  <= anodo_d;
            catodo_q <= catodo_d;
            digito_q <= digito_d;
            tick_q   <= tick_d;
        end
    end

    assign io.anodo      = anodo_q;
    assign io.catodo     = catodo_q;
    assign io.digito     = digito_q;
    assign io.frame_tick = tick_q;
endmodule

// File: tb/tb_multiplexor_display.sv
// tb_multiplexor_display: directed checks of scan order, blanking, latching, enable and reset,
// on a DIV=8/BLANK_CYC=2 build and a DIV=8/BLANK_CYC=0 build sharing clock and reset.
module tb_multiplexor_display;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    logic [3:0] ano [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] pat [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};

    multiplexor_display_if bus ();
    multiplexor_display_if bus0 ();

    multiplexor_display #(.DIV(8), .BLANK_CYC(2), .CW(4)) dut (.clk(clk), .reset(reset), .io(bus));
    multiplexor_display #(.DIV(8), .BLANK_CYC(0), .CW(4)) dut0 (.clk(clk), .reset(reset), .io(bus0));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_reset_state();
        vecs++;
        if (bus.anodo !== 4'hF || bus.catodo !== 8'hFF || bus.digito !== 2'd0 || bus.frame_tick !== 1'b0) begin
            errs++;
            $display("FAIL reset_state got %b/%h/%0d/%b exp 1111/ff/0/0", bus.anodo, bus.catodo, bus.digito, bus.frame_tick);
        end
    endtask

    // Edge k (1-based after release) processes cnt=(k-1)%8 of digit ((k-1)/8)%4.
    task automatic test_scan();
        restart();
        for (int k = 1; k <= 40; k++) begin
            int c = (k - 1) % 8;
            int d = ((k - 1) / 8) % 4;
            logic [3:0] ea = c < 2 ? 4'hF : ano[d];
            logic [7:0] ec = c < 2 ? 8'hFF : pat[d];
            logic       et = (c == 7 && d == 3);
            step();
            vecs++;
            if (bus.anodo !== ea || bus.catodo !== ec || bus.digito !== 2'(d) || bus.frame_tick !== et) begin
                errs++;
                $display("FAIL scan k=%0d got %b/%h/%0d/%b exp %b/%h/%0d/%b", k, bus.anodo, bus.catodo,
                         bus.digito, bus.frame_tick, ea, ec, d, et);
            end
        end
    endtask

    task automatic test_reset();
        restart();
        repeat (19) step();
        vecs++;
        if (bus.anodo !== 4'hB || bus.catodo !== 8'hA4) begin
            errs++;
            $display("FAIL pre_reset_show got %b/%h exp 1011/a4", bus.anodo, bus.catodo);
        end
        #2 reset = 1'b1;
        #1;
        vecs++;
        if (bus.anodo !== 4'hF || bus.catodo !== 8'hFF || bus.digito !== 2'd0 || bus.frame_tick !== 1'b0) begin
            errs++;
            $display("FAIL async_reset got %b/%h/%0d/%b exp 1111/ff/0/0", bus.anodo, bus.catodo, bus.digito, bus.frame_tick);
        end
        repeat (3) step();
        vecs++;
        if (bus.anodo !== 4'hF || bus.catodo !== 8'hFF || bus.digito !== 2'd0) begin
            errs++;
            $display("FAIL reset_hold got %b/%h/%0d exp 1111/ff/0", bus.anodo, bus.catodo, bus.digito);
        end
        @(negedge clk) reset = 1'b0;
        repeat (2) step();
        vecs++;
        if (bus.anodo !== 4'hF) begin
            errs++;
            $display("FAIL post_reset_blank got %b exp 1111", bus.anodo);
        end
        step();
        vecs++;
        if (bus.anodo !== 4'hE || bus.catodo !== 8'hC0) begin
            errs++;
            $display("FAIL post_reset_show got %b/%h exp 1110/c0", bus.anodo, bus.catodo);
        end
    endtask

    task automatic test_midchange();
        restart();
        repeat (3) step();
        bus.catodo1 = 8'h80;
        bus0.catodo1 = 8'h80;
        for (int k = 4; k <= 8; k++) begin
            step();
            vecs++;
            if (bus.anodo !== 4'hE || bus.catodo !== 8'hC0) begin
                errs++;
                $display("FAIL midchange_hold k=%0d got %b/%h exp 1110/c0", k, bus.anodo, bus.catodo);
            end
        end
        repeat (26) step();
        for (int k = 35; k <= 40; k++) begin
            step();
            vecs++;
            if (bus.anodo !== 4'hE || bus.catodo !== 8'h80) begin
                errs++;
                $display("FAIL midchange_new k=%0d got %b/%h exp 1110/80", k, bus.anodo, bus.catodo);
            end
        end
        bus.catodo1 = 8'hC0;
        bus0.catodo1 = 8'hC0;
    endtask

    task automatic test_en_drop();
        restart();
        repeat (19) step();
        bus.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            vecs++;
            if (bus.anodo !== 4'hF || bus.catodo !== 8'hFF || bus.digito !== 2'd0 || bus.frame_tick !== 1'b0) begin
                errs++;
                $display("FAIL en_low k=%0d got %b/%h/%0d/%b exp 1111/ff/0/0", k, bus.anodo, bus.catodo,
                         bus.digito, bus.frame_tick);
            end
        end
        bus.en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            vecs++;
            if (bus.anodo !== (k < 3 ? 4'hF : 4'hE) || bus.catodo !== (k < 3 ? 8'hFF : 8'hC0) || bus.digito !== 2'd0) begin
                errs++;
                $display("FAIL en_resume k=%0d got %b/%h/%0d", k, bus.anodo, bus.catodo, bus.digito);
            end
        end
    endtask

    task automatic test_blank0();
        restart();
        vecs++;
        if (bus0.anodo !== 4'hF) begin
            errs++;
            $display("FAIL blank0_reset got %b exp 1111", bus0.anodo);
        end
        for (int k = 1; k <= 40; k++) begin
            int d = ((k - 1) / 8) % 4;
            step();
            vecs++;
            if (bus0.anodo !== ano[d] || bus0.catodo !== pat[d] || $countones(~bus0.anodo) != 1 ||
                bus0.frame_tick !== (k == 32)) begin
                errs++;
                $display("FAIL blank0 k=%0d got %b/%h/%b exp %b/%h/%b", k, bus0.anodo, bus0.catodo,
                         bus0.frame_tick, ano[d], pat[d], k == 32);
            end
        end
    endtask

    initial begin
        bus.en = 1'b1;
        bus0.en = 1'b1;
        {bus.catodo1, bus.catodo2, bus.catodo3, bus.catodo4} = {8'hC0, 8'hF9, 8'hA4, 8'hB0};
        {bus0.catodo1, bus0.catodo2, bus0.catodo3, bus0.catodo4} = {8'hC0, 8'hF9, 8'hA4, 8'hB0};
        #12;
        test_reset_state();
        test_scan();
        test_reset();
        test_midchange();
        test_en_drop();
        test_blank0();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/multiplexor_display.md
# multiplexor_display

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It takes the four per-digit segment patterns `catodo1`..`catodo4` produced by the BCD-to-segment decoder and scans them onto the board's shared cathode bus. It drives one active-low anode line at a time, with a programmable blanking gap between digits to suppress ghosting. It sits between the decoder and the display pins.

## Interface
Parameters:
- `DIV`, 50000: clock cycles per digit slot (100 MHz gives a 2 kHz slot rate and a 500 Hz frame rate); must be ≥ 2.
- `BLANK_CYC`, 500: blanked cycles at the start of each slot; 0 ≤ `BLANK_CYC` < `DIV`.
- `CW`, 16: width of the slot counter; must satisfy 2^`CW` ≥ `DIV`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  scan enable; 0 blanks the display and restarts the scan.
- `catodo1`  in  8  segment pattern for digit 0 (rightmost), active-low, bit 7 = dp.
- `catodo2`  in  8  segment pattern for digit 1.
- `catodo3`  in  8  segment pattern for digit 2.
- `catodo4`  in  8  segment pattern for digit 3 (leftmost).
- `anodo`  out  4  anode enables, active-low, one-hot-zero or all ones.
- `catodo`  out  8  shared segment bus, active-low.
- `digito`  out  2  index of the slot currently on the outputs.
- `frame_tick`  out  1  one-cycle pulse at the end of the digit-3 slot.

## Operation
- Internal state: slot counter `cnt` (0..`DIV`-1), digit index `idx` (0..3), phase `BLANK`/`SHOW`, and an 8-bit latch `seg`.
- `cnt` increments on every enabled edge. When `cnt`==`DIV`-1 it wraps to 0 and `idx` advances. `idx` wraps from 3 to 0.
- Phase rule: `cnt` < `BLANK_CYC` selects `BLANK`; otherwise the phase is `SHOW`.
- Input sampling: `seg` captures `catodo{idx+1}` on the edge where `cnt`==`BLANK_CYC`, which is the entry into `SHOW`. Input changes after that edge are not shown until the same digit's next slot.
- Outputs in `BLANK`: `anodo`=4'b1111, `catodo`=8'hFF.
- Outputs in `SHOW`: `anodo`=~(4'b0001<<`idx`), `catodo`=`seg`.
- `digito`=`idx` in both phases.
- `frame_tick`=1 for exactly the one cycle after the edge where `cnt`==`DIV`-1 and `idx`==3.
- At no time is more than one `anodo` bit low.
- `en`=0 takes effect on the next edge: `cnt`←0, `idx`←0, phase `BLANK`, `anodo`=1111, `catodo`=FF, `frame_tick`=0, `digito`=0. These values hold while `en`=0. When `en` returns to 1, the scan restarts at digit 0 with a full blank phase.
- Reset: asynchronous, effective immediately and independent of `clk`, including mid-slot or mid-`SHOW`. It sets `cnt`=0, `idx`=0, `seg`=8'hFF, `anodo`=4'b1111, `catodo`=8'hFF, `digito`=0, `frame_tick`=0. The first enabled edge after release begins slot 0 at its blank phase.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- An output change appears one cycle after the counter condition that causes it.
- Each slot is exactly `DIV` cycles long: `BLANK_CYC` cycles blank followed by `DIV`-`BLANK_CYC` cycles lit.
- A frame is 4×`DIV` cycles, and `frame_tick` occurs once per frame.
- `BLANK_CYC`=0: no blank cycles. The anode switches directly from digit i to digit i+1 on one edge, and the new pattern is latched on that same edge.
- Latency from a `catodoN` change to visibility: at most 4×`DIV` cycles, at least 1 cycle (when the change lands just before that digit's `SHOW` entry).

## Test plan
Bench parameters: `DIV`=8, `BLANK_CYC`=2. Inputs: `catodo1`=C0, `catodo2`=F9, `catodo3`=A4, `catodo4`=B0.
- Reset: assert `reset` mid-`SHOW` of digit 2, between clock edges → immediately `anodo`=1111, `catodo`=FF, `digito`=0, `frame_tick`=0; all hold while reset is high.
- Scan order after reset release with `en`=1 → per 8-cycle slot, 2 cycles of 1111/FF, then 6 cycles of each pair in turn: 1110/C0, 1101/F9, 1011/A4, 0111/B0. `frame_tick` pulses once every 32 cycles, on the cycle after digit 3's last count. Digit 0 follows again (wrap).
- Mid-slot input change: set `catodo1`=80 during digit 0 `SHOW` → `catodo` stays C0 for the rest of the slot and shows 80 only in the next frame's digit-0 slot.
- Enable drop: deassert `en` during digit 2 `SHOW` → next edge 1111/FF, `digito`=0. Reassert `en` → 2 blank cycles, then 1110/C0.
- `BLANK_CYC`=0 build: anodes 1110→1101→1011→0111, 8 cycles each, with no 1111 cycle after the first post-reset edge. Check that exactly one `anodo` bit is low throughout.
